// File: rtl/idann_pkg.sv
// Shared constants and FSM state type for the result serializer.
package idann_pkg;

    localparam int          FINAL_W    = 23;
    localparam int          LOSS_W     = 46;
    localparam logic [7:0]  HDR        = 8'hA5;
    localparam int          FRAME_LEN  = 11;
    localparam int          FIN_BYTES  = 3;
    localparam int          LOSS_BYTES = 6;

    // FIN and LOSS leave when idx reaches their last byte position.
    localparam logic [2:0]  FIN_LAST   = 3'(FIN_BYTES - 1);
    localparam logic [2:0]  LOSS_LAST  = 3'(LOSS_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_FIN,
        S_LOSS,
        S_CSUM
    } ser_state_e;

endpackage

// File: rtl/result_serializer_byte_sel.sv
// Combinational byte picker: chooses the frame byte for the current state and index.
module ser_byte_sel
    import idann_pkg::*;
(
    input  ser_state_e          state,
    input  logic [2:0]          idx,
    input  logic [FINAL_W-1:0]  fin_q,
    input  logic [LOSS_W-1:0]   loss_q,
    input  logic [7:0]          csum,
    output logic [7:0]          byte_o
);

    logic [8*FIN_BYTES-1:0]  fin_ext;
    logic [8*LOSS_BYTES-1:0] loss_ext;

    assign fin_ext  = {{(8*FIN_BYTES-FINAL_W){1'b0}}, fin_q};
    assign loss_ext = {{(8*LOSS_BYTES-LOSS_W){1'b0}}, loss_q};

    always_comb begin
        byte_o = 8'h00;
        unique case (state)
            S_HDR:  byte_o = HDR;
            S_FIN: begin
                case (idx)
                    3'd0:    byte_o = fin_ext[7:0];
                    3'd1:    byte_o = fin_ext[15:8];
                    3'd2:    byte_o = fin_ext[23:16];
                    default: byte_o = 8'h00;
                endcase
            end
            S_LOSS: begin
                case (idx)
                    3'd0:    byte_o = loss_ext[7:0];
                    3'd1:    byte_o = loss_ext[15:8];
                    3'd2:    byte_o = loss_ext[23:16];
                    3'd3:    byte_o = loss_ext[31:24];
                    3'd4:    byte_o = loss_ext[39:32];
                    3'd5:    byte_o = loss_ext[47:40];
                    default: byte_o = 8'h00;
                endcase
            end
            S_CSUM: byte_o = csum;
            default: byte_o = 8'h00;
        endcase
    end

endmodule

// File: rtl/result_serializer.sv
// Latches one (final, loss) result on capture and streams it as an 11-byte
// HDR/final/loss/checksum frame over a byte-wide valid/ready link.
module result_serializer
    import idann_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                en_i,
    input  logic                capture_i,
    input  logic [FINAL_W-1:0]  final_i,
    input  logic [LOSS_W-1:0]   loss_i,
    input  logic                ready_i,
    output logic [7:0]          byte_o,
    output logic                valid_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                overrun_o
);

    ser_state_e          state_q, state_d;
    logic [2:0]          idx_q;
    logic [7:0]          csum_q;
    logic [FINAL_W-1:0]  fin_q;
    logic [LOSS_W-1:0]   loss_q;
    logic                done_q;
    logic                overrun_q;

    logic xfer, csum_xfer, cap_req, accept, drop, payload_xfer;

    assign valid_o      = (state_q != S_IDLE);
    assign busy_o       = (state_q != S_IDLE);
    assign done_o       = done_q;
    assign overrun_o    = overrun_q;

    assign xfer         = valid_o && ready_i;
    assign csum_xfer    = xfer && (state_q == S_CSUM);
    assign payload_xfer = xfer && ((state_q == S_FIN) || (state_q == S_LOSS));
    assign cap_req      = capture_i && en_i;
    // The checksum-transfer cycle frees the latch, so a capture there chains a new frame.
    assign accept       = cap_req && ((state_q == S_IDLE) || csum_xfer);
    assign drop         = cap_req && !accept;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (accept) state_d = S_HDR;
            S_HDR:  if (xfer) state_d = S_FIN;
            S_FIN:  if (xfer && idx_q == FIN_LAST) state_d = S_LOSS;
            S_LOSS: if (xfer && idx_q == LOSS_LAST) state_d = S_CSUM;
            S_CSUM: if (xfer) state_d = accept ? S_HDR : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            idx_q     <= 3'd0;
            csum_q    <= 8'h00;
            fin_q     <= '0;
            loss_q    <= '0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= csum_xfer;

            if (state_d != state_q) idx_q <= 3'd0;
            else if (payload_xfer)  idx_q <= idx_q + 3'd1;

            if (accept) begin
                fin_q  <= final_i;
                loss_q <= loss_i;
                csum_q <= 8'h00;
            end else if (payload_xfer) begin
                csum_q <= csum_q ^ byte_o;
            end

            if (drop) overrun_q <= 1'b1;
        end
    end

    ser_byte_sel u_byte_sel (
        .state  (state_q),
        .idx    (idx_q),
        .fin_q  (fin_q),
        .loss_q (loss_q),
        .csum   (csum_q),
        .byte_o (byte_o)
    );

endmodule
